neuron_fetch_controller: RTL and testbench

Sequencer for the neuron fetch unit. It drives the read port of the input-neuron buffer and generates the fetch unit's four enables: `addressing_en`, `channel_switch_en`, `store_data_en` and `output_neuron_ac_en`. For each output position it walks one convolution window: it loads one 7-byte word per filter row, streams `filter_width+1` activations out of that word, and rotates the begin channel to step one column right. It sits between the layer control FSM (`start_i`/`done_o`) and one fetch unit.

---
 rtl/neuron_fetch_controller.sv | 219 +++++++++++++++++++++
 tb/tb_neuron_fetch_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_fetch_controller.sv
// Neuron fetch sequencer: walks one convolution window per output position and
// drives the input-neuron buffer read port plus the fetch unit's four enables.
module neuron_fetch_controller #(
    parameter int ADDR_BIT_WIDTH         = 10,
    parameter int FILTER_WIDTH_BIT_WIDTH = 3,
    parameter int DIM_BIT_WIDTH          = 8
) (
    input  logic                              clk,
    input  logic                              layer_reset,
    input  logic                              start_i,
    input  logic [FILTER_WIDTH_BIT_WIDTH-1:0] filter_width_i,
    input  logic [DIM_BIT_WIDTH-1:0]          out_width_i,
    input  logic [DIM_BIT_WIDTH-1:0]          out_height_i,
    input  logic [ADDR_BIT_WIDTH-1:0]         base_addr_i,
    input  logic [ADDR_BIT_WIDTH-1:0]         row_stride_i,
    output logic                              mem_rd_en_o,
    output logic [ADDR_BIT_WIDTH-1:0]         mem_addr_o,
    output logic                              store_data_en_o,
    output logic                              output_neuron_ac_en_o,
    output logic                              channel_switch_en_o,
    output logic                              addressing_en_o,
    output logic                              busy_o,
    output logic                              done_o
);

    localparam logic [FILTER_WIDTH_BIT_WIDTH-1:0] FW_MAX    = FILTER_WIDTH_BIT_WIDTH'(5);
    localparam logic [2:0]                        CHAN_LAST = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_STORE,
        S_STREAM,
        S_CSW,
        S_ADR,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Configuration latched at start
    logic [FILTER_WIDTH_BIT_WIDTH-1:0] fw;
    logic [DIM_BIT_WIDTH-1:0]          out_width;
    logic [DIM_BIT_WIDTH-1:0]          out_height;
    logic [ADDR_BIT_WIDTH-1:0]         row_stride;

    // Window walk counters and address components
    logic [FILTER_WIDTH_BIT_WIDTH-1:0] idx;
    logic [FILTER_WIDTH_BIT_WIDTH-1:0] kr;
    logic [2:0]                        chan;
    logic [DIM_BIT_WIDTH-1:0]          col;
    logic [DIM_BIT_WIDTH-1:0]          row;
    logic [ADDR_BIT_WIDTH-1:0]         row_base;
    logic [ADDR_BIT_WIDTH-1:0]         col_word;
    logic [ADDR_BIT_WIDTH-1:0]         kr_off;

    logic       start_accept;
    logic       idx_last;
    logic       kr_last;
    logic       col_last;
    logic       row_last;
    logic [2:0] chan_next;

    assign start_accept = (state == S_IDLE) && start_i;
    assign idx_last     = (idx == fw);
    assign kr_last      = (kr == fw);
    assign col_last     = (col == out_width);
    assign row_last     = (row == out_height);
    assign chan_next    = (chan == CHAN_LAST) ? 3'd0 : chan + 3'd1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers, independent of block order.
    always_ff @(posedge clk) begin
        if (layer_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    always_comb begin
        state_next            = state;
        mem_rd_en_o           = 1'b0;
        store_data_en_o       = 1'b0;
        output_neuron_ac_en_o = 1'b0;
        channel_switch_en_o   = 1'b0;
        addressing_en_o       = 1'b0;
        done_o                = 1'b0;
        busy_o                = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_next = S_READ;
                end
            end
            S_READ: begin
                mem_rd_en_o = 1'b1;
                state_next  = S_STORE;
            end
            S_STORE: begin
                store_data_en_o = 1'b1;
                state_next      = S_STREAM;
            end
            S_STREAM: begin
                output_neuron_ac_en_o = 1'b1;
                if (idx_last) begin
                    state_next = kr_last ? S_CSW : S_READ;
                end
            end
            S_CSW: begin
                // The fetch unit registers this enable, so it leads addressing by one cycle.
                channel_switch_en_o = 1'b1;
                state_next          = S_ADR;
            end
            S_ADR: begin
                addressing_en_o = 1'b1;
                if (!col_last) begin
                    state_next = S_READ;
                end else if (!row_last) begin
                    state_next = (chan_next != 3'd0) ? S_CSW : S_READ;
                end else begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done_o     = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Filter sizes beyond 6x6 are clamped to 6x6 when latched.
    always_ff @(posedge clk) begin
        if (layer_reset) begin
            fw         <= '0;
            out_width  <= '0;
            out_height <= '0;
            row_stride <= '0;
        end else if (start_accept) begin
            fw         <= (filter_width_i > FW_MAX) ? FW_MAX : filter_width_i;
            out_width  <= out_width_i;
            out_height <= out_height_i;
            row_stride <= row_stride_i;
        end
    end

    // Inner walk: activation index within a word and filter row within the window.
    always_ff @(posedge clk) begin
        if (layer_reset) begin
            idx    <= '0;
            kr     <= '0;
            kr_off <= '0;
        end else if (start_accept) begin
            idx    <= '0;
            kr     <= '0;
            kr_off <= '0;
        end else begin
            case (state)
                S_STORE: begin
                    idx <= '0;
                end
                S_STREAM: begin
                    if (!idx_last) begin
                        idx <= idx + FILTER_WIDTH_BIT_WIDTH'(1);
                    end else if (!kr_last) begin
                        kr     <= kr + FILTER_WIDTH_BIT_WIDTH'(1);
                        kr_off <= kr_off + row_stride;
                    end else begin
                        kr     <= '0;
                        kr_off <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outer walk: begin channel, output column/row and the word offsets they imply.
    always_ff @(posedge clk) begin
        if (layer_reset) begin
            chan     <= '0;
            col      <= '0;
            col_word <= '0;
            row      <= '0;
            row_base <= '0;
        end else if (start_accept) begin
            chan     <= '0;
            col      <= '0;
            col_word <= '0;
            row      <= '0;
            row_base <= base_addr_i;
        end else if (state == S_ADR) begin
            chan <= chan_next;
            if (chan == CHAN_LAST) begin
                col_word <= col_word + ADDR_BIT_WIDTH'(1);
            end
            if (!col_last) begin
                col <= col + DIM_BIT_WIDTH'(1);
            end else if (!row_last && (chan_next == 3'd0)) begin
                // Rows are word-aligned: a new row restarts at channel 0, word 0.
                col      <= '0;
                col_word <= '0;
                row      <= row + DIM_BIT_WIDTH'(1);
                row_base <= row_base + row_stride;
            end
        end
    end

    assign mem_addr_o = mem_rd_en_o ? (row_base + col_word + kr_off) : '0;

endmodule

// File: tb/tb_neuron_fetch_controller.sv
// Self-checking bench: a window-walk model builds the expected per-cycle trace
// of every pass, compared cycle by cycle against the controller.
module tb_neuron_fetch_controller;

    localparam int AW  = 10;
    localparam int FWW = 3;
    localparam int DW  = 8;

    logic           clk = 1'b0;
    logic           layer_reset;
    logic           start_i;
    logic [FWW-1:0] filter_width_i;
    logic [DW-1:0]  out_width_i;
    logic [DW-1:0]  out_height_i;
    logic [AW-1:0]  base_addr_i;
    logic [AW-1:0]  row_stride_i;
    logic           mem_rd_en_o;
    logic [AW-1:0]  mem_addr_o;
    logic           store_data_en_o;
    logic           output_neuron_ac_en_o;
    logic           channel_switch_en_o;
    logic           addressing_en_o;
    logic           busy_o;
    logic           done_o;

    neuron_fetch_controller #(
        .ADDR_BIT_WIDTH        (AW),
        .FILTER_WIDTH_BIT_WIDTH(FWW),
        .DIM_BIT_WIDTH         (DW)
    ) dut (
        .clk                  (clk),
        .layer_reset          (layer_reset),
        .start_i              (start_i),
        .filter_width_i       (filter_width_i),
        .out_width_i          (out_width_i),
        .out_height_i         (out_height_i),
        .base_addr_i          (base_addr_i),
        .row_stride_i         (row_stride_i),
        .mem_rd_en_o          (mem_rd_en_o),
        .mem_addr_o           (mem_addr_o),
        .store_data_en_o      (store_data_en_o),
        .output_neuron_ac_en_o(output_neuron_ac_en_o),
        .channel_switch_en_o  (channel_switch_en_o),
        .addressing_en_o      (addressing_en_o),
        .busy_o               (busy_o),
        .done_o               (done_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          rd;
        logic [AW-1:0] addr;
        logic          st;
        logic          ac;
        logic          csw;
        logic          adr;
        logic          busy;
        logic          done;
    } cyc_t;

    cyc_t          exp_q[$];
    logic [AW-1:0] dut_addrs[$];
    int            checks = 0;
    int            errors = 0;
    int            dut_ac;
    int            dut_done_cyc;
    int            dut_first_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic cyc_t mk(input logic rd, input int addr, input logic st, input logic ac,
                                input logic csw, input logic adr, input logic done);
        cyc_t c;
        c.rd   = rd;
        c.addr = rd ? AW'(addr) : '0;
        c.st   = st;
        c.ac   = ac;
        c.csw  = csw;
        c.adr  = adr;
        c.busy = 1'b1;
        c.done = done;
        return c;
    endfunction

    function automatic cyc_t dut_now();
        cyc_t c;
        c.rd   = mem_rd_en_o;
        c.addr = mem_addr_o;
        c.st   = store_data_en_o;
        c.ac   = output_neuron_ac_en_o;
        c.csw  = channel_switch_en_o;
        c.adr  = addressing_en_o;
        c.busy = busy_o;
        c.done = done_o;
        return c;
    endfunction

    // Expected trace: every output position is (fw+1) word loads of fw+1 activations
    // followed by a channel rotate; column c of a row lives c/7 words in; each
    // non-final row is padded with rotates until the channel count reaches a multiple of 7.
    task automatic build_model(input int fwi, input int ow, input int oh, input int base, input int stride);
        int fw;
        int pad;
        exp_q.delete();
        fw = (fwi > 5) ? 5 : fwi;
        for (int r = 0; r <= oh; r++) begin
            for (int c = 0; c <= ow; c++) begin
                for (int k = 0; k <= fw; k++) begin
                    exp_q.push_back(mk(1, base + r * stride + c / 7 + k * stride, 0, 0, 0, 0, 0));
                    exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 0));
                    for (int i = 0; i <= fw; i++) exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0));
                end
                exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0));
                exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0));
            end
            if (r < oh) begin
                pad = (7 - ((ow + 1) % 7)) % 7;
                for (int p = 0; p < pad; p++) begin
                    exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0));
                    exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0));
                end
            end
        end
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1));
    endtask

    task automatic check_reset_outputs(input string name);
        cyc_t zero;
        zero = '0;
        check(name, 32'(dut_now()), 32'(zero));
    endtask

    // Pulses start, then compares each cycle of the pass; noise pulses start and
    // scrambles the configuration inputs while busy; abort>0 resets at that cycle.
    task automatic run_pass(input string name, input int fwi, input int ow, input int oh,
                            input int base, input int stride, input bit noise, input int abort);
        cyc_t e;
        cyc_t a;
        int   n;
        build_model(fwi, ow, oh, base, stride);
        n              = exp_q.size();
        dut_ac         = 0;
        dut_done_cyc   = -1;
        dut_first_busy = -1;
        dut_addrs.delete();
        @(negedge clk);
        filter_width_i = FWW'(fwi);
        out_width_i    = DW'(ow);
        out_height_i   = DW'(oh);
        base_addr_i    = AW'(base);
        row_stride_i   = AW'(stride);
        start_i        = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            e = exp_q[k-1];
            a = dut_now();
            if (a.ac) dut_ac++;
            if (a.done && dut_done_cyc < 0) dut_done_cyc = k;
            if (a.busy && dut_first_busy < 0) dut_first_busy = k;
            if (a.rd) dut_addrs.push_back(a.addr);
            if (!e.rd) a.addr = '0;
            check($sformatf("%s trace c%0d", name, k), 32'(a), 32'(e));
            start_i = noise && (k % 5 == 2);
            if (noise) begin
                filter_width_i = FWW'($urandom);
                out_width_i    = DW'($urandom);
                out_height_i   = DW'($urandom);
                base_addr_i    = AW'($urandom);
                row_stride_i   = AW'($urandom);
            end
            if (k == abort) begin
                start_i     = 1'b0;
                layer_reset = 1'b1;
                @(negedge clk);
                layer_reset = 1'b0;
                check_reset_outputs($sformatf("%s after reset", name));
                return;
            end
        end
        start_i = 1'b0;
        @(negedge clk);
        e = '0;
        a = dut_now();
        a.addr = '0;
        check($sformatf("%s idle after done", name), 32'(a), 32'(e));
    endtask

    initial begin
        layer_reset    = 1'b1;
        start_i        = 1'b0;
        filter_width_i = '0;
        out_width_i    = '0;
        out_height_i   = '0;
        base_addr_i    = '0;
        row_stride_i   = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset state");
        layer_reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("idle without start");

        // fw=0, 1x1, base=5
        run_pass("s1", 0, 0, 0, 5, 3, 1'b0, 0);
        check("s1 trace length", 32'(exp_q.size()), 32'd6);
        check("s1 done cycle", 32'(dut_done_cyc), 32'd6);
        check("s1 first busy cycle", 32'(dut_first_busy), 32'd1);
        check("s1 read addr", 32'(dut_addrs[0]), 32'd5);

        // fw=2, 3x1, stride 4, with start pulses and input churn while busy
        run_pass("s2", 2, 2, 0, 0, 4, 1'b1, 0);
        check("s2 trace length", 32'(exp_q.size()), 32'd52);
        check("s2 addr0", 32'(dut_addrs[0]), 32'd0);
        check("s2 addr1", 32'(dut_addrs[1]), 32'd4);
        check("s2 addr2", 32'(dut_addrs[2]), 32'd8);
        check("s2 ac count", 32'(dut_ac), 32'd27);

        // Reset in the middle of STREAM, then the same pass again from scratch
        run_pass("s2 abort", 2, 2, 0, 0, 4, 1'b0, 8);
        run_pass("s2 rerun", 2, 2, 0, 0, 4, 1'b0, 0);
        check("s2 rerun done cycle", 32'(dut_done_cyc), 32'd52);

        // fw=5, 8x2, stride 2: column word step and row realignment
        run_pass("s3", 5, 7, 1, 0, 2, 1'b0, 0);
        check("s3 trace length", 32'(exp_q.size()), 32'd813);
        check("s3 ac count", 32'(dut_ac), 32'd576);
        check("s3 col7 first addr", 32'(dut_addrs[42]), 32'd1);
        check("s3 row1 first addr", 32'(dut_addrs[48]), 32'd2);

        // Address wrap at 2^10
        run_pass("wrap", 2, 0, 0, 1022, 1, 1'b0, 0);
        check("wrap addr0", 32'(dut_addrs[0]), 32'd1022);
        check("wrap addr1", 32'(dut_addrs[1]), 32'd1023);
        check("wrap addr2", 32'(dut_addrs[2]), 32'd0);

        // filter_width 7 behaves as 5
        run_pass("fw7", 7, 1, 0, 10, 3, 1'b1, 0);
        check("fw7 trace length", 32'(exp_q.size()), 32'd101);
        check("fw7 ac count", 32'(dut_ac), 32'd72);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
